// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and data access.
// Each transfer is sequenced IDLE -> ACCESS (WAIT_CYCLES) -> DONE with a one-cycle ack.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              grant_data, grant_data_n;
    logic              last_data, last_data_n;
    logic              we_l, we_l_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;
    logic [DATA_W-1:0] if_rdata_n, d_rdata_n;
    logic              mem_ce_n, mem_we_n, if_ack_n, d_ack_n;
    logic              pick_data;

    // Data wins when it is the only requester, or on contention when instruction went last.
    assign pick_data = d_req & (~if_req | ~last_data);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        grant_data_n = grant_data;
        last_data_n  = last_data;
        we_l_n       = we_l;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        if_rdata_n   = if_rdata;
        d_rdata_n    = d_rdata;

        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    grant_data_n = pick_data;
                    last_data_n  = pick_data;
                    mem_addr_n   = pick_data ? d_addr : if_addr;
                    we_l_n       = pick_data & d_we;
                    if (pick_data) begin
                        mem_wdata_n = d_wdata;
                    end
                    cnt_n   = CNT_W'(WAIT_CYCLES - 1);
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    if (!grant_data) begin
                        if_rdata_n = mem_rdata;
                    end else if (!we_l) begin
                        d_rdata_n = mem_rdata;
                    end
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Strobes are registered from the next state so they line up with it.
        mem_ce_n = (state_n == ACCESS);
        mem_we_n = (state_n == ACCESS) & we_l_n;
        if_ack_n = (state_n == DONE) & ~grant_data_n;
        d_ack_n  = (state_n == DONE) & grant_data_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            grant_data <= 1'b0;
            last_data  <= 1'b0;
            we_l       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            grant_data <= grant_data_n;
            last_data  <= last_data_n;
            we_l       <= we_l_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            if_rdata   <= if_rdata_n;
            d_rdata    <= d_rdata_n;
            mem_ce     <= mem_ce_n;
            mem_we     <= mem_we_n;
            if_ack     <= if_ack_n;
            d_ack      <= d_ack_n;
        end
    end

    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: WAIT_CYCLES=2 instance plus a WAIT_CYCLES=1 instance.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        if_req, if_ack, if_stall, d_req, d_we, d_ack, d_stall;
    logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic        mem_ce, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic        w1_if_req, w1_if_ack, w1_if_stall, w1_d_req, w1_d_we, w1_d_ack, w1_d_stall;
    logic [15:0] w1_if_addr, w1_if_rdata, w1_d_addr, w1_d_wdata, w1_d_rdata;
    logic        w1_mem_ce, w1_mem_we;
    logic [15:0] w1_mem_addr, w1_mem_wdata, w1_mem_rdata;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    // Memory model: one fixed word at 0x0010, otherwise address XOR 0xC3C3.
    assign mem_rdata    = (mem_addr == 16'h0010) ? 16'hA5A5 : (mem_addr ^ 16'hC3C3);
    assign w1_mem_rdata = w1_mem_addr ^ 16'hC3C3;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_ack(d_ack), .d_stall(d_stall),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .if_req(w1_if_req), .if_addr(w1_if_addr), .if_rdata(w1_if_rdata), .if_ack(w1_if_ack),
        .if_stall(w1_if_stall),
        .d_req(w1_d_req), .d_we(w1_d_we), .d_addr(w1_d_addr), .d_wdata(w1_d_wdata),
        .d_rdata(w1_d_rdata), .d_ack(w1_d_ack), .d_stall(w1_d_stall),
        .mem_ce(w1_mem_ce), .mem_we(w1_mem_we), .mem_addr(w1_mem_addr), .mem_wdata(w1_mem_wdata),
        .mem_rdata(w1_mem_rdata)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        w1_if_req = 0; w1_if_addr = '0; w1_d_req = 0; w1_d_we = 0; w1_d_addr = '0; w1_d_wdata = '0;
        #1;
        check("rst_if_ack", 16'(if_ack), 16'd0);
        check("rst_d_ack", 16'(d_ack), 16'd0);
        check("rst_mem_ce", 16'(mem_ce), 16'd0);
        check("rst_mem_we", 16'(mem_we), 16'd0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_if_rdata", if_rdata, 16'h0000);
        check("rst_d_rdata", d_rdata, 16'h0000);
        step();
        rst = 1'b1;

        // Lone fetch
        if_req = 1; if_addr = 16'h0010;
        #1;
        check("fetch_c0_stall", 16'(if_stall), 16'd1);
        check("fetch_c0_ce", 16'(mem_ce), 16'd0);
        step();
        check("fetch_c1_ce", 16'(mem_ce), 16'd1);
        check("fetch_c1_addr", mem_addr, 16'h0010);
        check("fetch_c1_we", 16'(mem_we), 16'd0);
        check("fetch_c1_stall", 16'(if_stall), 16'd1);
        step();
        check("fetch_c2_ce", 16'(mem_ce), 16'd1);
        check("fetch_c2_ack", 16'(if_ack), 16'd0);
        check("fetch_c2_stall", 16'(if_stall), 16'd1);
        step();
        check("fetch_c3_ack", 16'(if_ack), 16'd1);
        check("fetch_c3_rdata", if_rdata, 16'hA5A5);
        check("fetch_c3_stall", 16'(if_stall), 16'd0);
        check("fetch_c3_ce", 16'(mem_ce), 16'd0);
        if_req = 0;
        step();
        check("fetch_c4_ack", 16'(if_ack), 16'd0);

        // Store
        d_req = 1; d_we = 1; d_addr = 16'h8000; d_wdata = 16'h1234;
        step();
        check("store_c1_we", 16'(mem_we), 16'd1);
        check("store_c1_addr", mem_addr, 16'h8000);
        check("store_c1_wdata", mem_wdata, 16'h1234);
        step();
        check("store_c2_we", 16'(mem_we), 16'd1);
        check("store_c2_ce", 16'(mem_ce), 16'd1);
        step();
        check("store_c3_ack", 16'(d_ack), 16'd1);
        check("store_c3_rdata", d_rdata, 16'h0000);
        check("store_c3_we", 16'(mem_we), 16'd0);
        d_req = 0; d_we = 0;
        step();
        check("store_c4_ack", 16'(d_ack), 16'd0);

        // Contention after reset: DATA, INST, DATA, INST
        rst = 1'b0;
        step();
        rst = 1'b1;
        if_req = 1; if_addr = 16'h0300; d_req = 1; d_we = 0; d_addr = 16'h0200;
        for (int c = 1; c <= 16; c++) begin
            step();
            check($sformatf("cont_c%0d_d_ack", c), 16'(d_ack), 16'((c % 8) == 3));
            check($sformatf("cont_c%0d_if_ack", c), 16'(if_ack), 16'((c % 8) == 7));
            if ((c % 4) == 1)
                check($sformatf("cont_c%0d_addr", c), mem_addr, ((c % 8) == 1) ? 16'h0200 : 16'h0300);
            if (c == 3) check("cont_d_rdata", d_rdata, 16'hC1C3);
            if (c == 7) check("cont_if_rdata", if_rdata, 16'hC0C3);
            if (c == 15) begin
                if_req = 0; d_req = 0;
            end
        end

        // Back-to-back loads
        d_req = 1; d_we = 0; d_addr = 16'h0100;
        step(); step();
        check("b2b_c2_ack", 16'(d_ack), 16'd0);
        step();
        check("b2b_c3_ack", 16'(d_ack), 16'd1);
        check("b2b_c3_rdata", d_rdata, 16'hC2C3);
        d_addr = 16'h0101;
        step(); step(); step();
        check("b2b_c6_ack", 16'(d_ack), 16'd0);
        step();
        check("b2b_c7_ack", 16'(d_ack), 16'd1);
        check("b2b_c7_rdata", d_rdata, 16'hC2C2);
        d_req = 0;
        step();

        // Async reset during second ACCESS cycle of a store
        d_req = 1; d_we = 1; d_addr = 16'h4444; d_wdata = 16'hBEEF;
        step(); step();
        check("areset_pre_ce", 16'(mem_ce), 16'd1);
        check("areset_pre_we", 16'(mem_we), 16'd1);
        #2 rst = 1'b0;
        #1;
        check("areset_ce_drop", 16'(mem_ce), 16'd0);
        check("areset_we_drop", 16'(mem_we), 16'd0);
        check("areset_addr", mem_addr, 16'h0000);
        d_req = 0; d_we = 0;
        step();
        check("areset_no_ack_a", 16'(d_ack), 16'd0);
        step();
        rst = 1'b1;
        step();
        check("areset_idle_ce", 16'(mem_ce), 16'd0);
        check("areset_no_ack_b", 16'(d_ack), 16'd0);
        if_req = 1; if_addr = 16'h0500; d_req = 1; d_addr = 16'h0600;
        step();
        check("areset_grant_data", mem_addr, 16'h0600);
        step(); step();
        check("areset_d_ack", 16'(d_ack), 16'd1);
        check("areset_d_rdata", d_rdata, 16'hC5C3);
        if_req = 0; d_req = 0;
        step();

        // WAIT_CYCLES=1 instance: lone load
        w1_d_req = 1; w1_d_we = 0; w1_d_addr = 16'h0002;
        #1;
        check("w1_c0_ce", 16'(w1_mem_ce), 16'd0);
        step();
        check("w1_c1_ce", 16'(w1_mem_ce), 16'd1);
        check("w1_c1_ack", 16'(w1_d_ack), 16'd0);
        step();
        check("w1_c2_ack", 16'(w1_d_ack), 16'd1);
        check("w1_c2_ce", 16'(w1_mem_ce), 16'd0);
        check("w1_c2_rdata", w1_d_rdata, 16'hC3C1);
        w1_d_req = 0;
        step();
        check("w1_c3_ack", 16'(w1_d_ack), 16'd0);
        check("w1_c3_ce", 16'(w1_mem_ce), 16'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port 16-bit program/data memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage load/store). It sequences each multi-cycle memory access with a small FSM and raises per-port stall signals that freeze the pipeline stage registers while a request is outstanding. Round-robin arbitration under contention prevents either stage from starving the other.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data word width
WAIT_CYCLES, 2, memory access cycles per transfer (legal range 1..15)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
if_req  in  1  instruction fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address, stable while if_req high
if_rdata  out  DATA_W  fetched word, valid when if_ack high, held until next if_ack
if_ack  out  1  one-cycle completion pulse, instruction port
if_stall  out  1  if_req & ~if_ack (combinational)
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = store, 0 = load; stable while d_req high
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid when d_ack high, held until next d_ack
d_ack  out  1  one-cycle completion pulse, data port
d_stall  out  1  d_req & ~d_ack (combinational)
mem_ce  out  1  memory chip enable, high during ACCESS
mem_we  out  1  memory write enable, high during ACCESS of a store
mem_addr  out  ADDR_W  latched address of granted access
mem_wdata  out  DATA_W  latched store data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (rst low, async): state IDLE; cnt 0; if_ack, d_ack, mem_ce, mem_we 0; mem_addr, mem_wdata, if_rdata, d_rdata 0; last_grant = INST. Reset mid-access aborts immediately: mem_ce/mem_we drop without waiting for a clock edge, no ack is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: sample requests.
  - Only d_req: grant DATA.
  - Only if_req: grant INST.
  - Both: grant the port opposite last_grant.
  - None: stay.
  - On grant: latch addr (and d_we, d_wdata for DATA) into mem_addr/mem_we_l/mem_wdata; cnt = WAIT_CYCLES-1; update last_grant; go to ACCESS.
- ACCESS: mem_ce = 1; mem_we = latched we (DATA grant only, else 0); address and data held constant for all WAIT_CYCLES cycles.
  - cnt != 0: decrement.
  - cnt == 0: capture mem_rdata into the granted port's rdata register (loads and fetches only; stores leave d_rdata unchanged); go to DONE.
- DONE: mem_ce = mem_we = 0; assert the granted port's ack for exactly one cycle; go to IDLE.
- Latency: request first seen in IDLE cycle 0 gives ACCESS in cycles 1..WAIT_CYCLES and ack in cycle WAIT_CYCLES+1. Throughput is one transfer per WAIT_CYCLES+2 cycles.
- Requester contract: at the posedge where it samples ack=1, the requester must drop req or present its next request. Any req high in IDLE is a new request.
- Request inputs are ignored outside IDLE. Changes to an ungranted port's inputs during ACCESS/DONE have no effect on the current transfer.
- Stalls: the pipeline ORs if_stall | d_stall into stage-register hold enables. Stall deasserts in the ack cycle.
- WAIT_CYCLES = 1: ACCESS lasts a single cycle (cnt starts at 0).

Test Plan:
- Reset then lone fetch (WAIT_CYCLES=2): if_req=1, if_addr=0x0010, mem returns 0xA5A5 -> mem_ce high cycles 1-2, if_ack pulse in cycle 3, if_rdata=0xA5A5, if_stall high in cycles 0-2 and low in cycle 3.
- Store: d_req=1, d_we=1, d_addr=0x8000, d_wdata=0x1234 -> mem_we=1 with mem_addr=0x8000 and mem_wdata=0x1234 for 2 cycles, d_ack in cycle 3, d_rdata unchanged.
- Contention after reset: if_req and d_req both held high -> grant order DATA, INST, DATA, INST; acks 4 cycles apart; no port is granted twice in a row.
- Back-to-back loads: requester re-presents d_req in the cycle after each ack with addresses 0x0100, 0x0101 -> two d_acks exactly 4 cycles apart, each with the correct d_rdata.
- Async reset asserted during the second ACCESS cycle of a store -> mem_ce/mem_we fall before the next edge, no d_ack, state IDLE and last_grant=INST after release.
- WAIT_CYCLES=1 build: lone load at 0x0002 -> ack in cycle 2, mem_ce high for exactly 1 cycle.
